// File: rtl/io_latch_arbiter.sv
// io_latch_arbiter: presets the output latch bank, then arbitrates two
// requesters round-robin onto the shared latch write path with setup/strobe/ack.
// Ports: clk, Rn (async active-low reset)
//        req0/addr0/data0, req1/addr1/data1 : requester inputs
//        gnt0/gnt1, done0/done1, err       : handshake outputs
//        lat_d, lat_ce (one-hot), lat_Sn    : latch bank drive
//        busy                               : high outside IDLE
module io_latch_arbiter #(
  parameter  int NLATCH     = 8,
  parameter  int DW         = 8,
  parameter  int HOLD       = 2,
  parameter  int PRESET_CYC = 4,
  localparam int AW         = (NLATCH > 1) ? $clog2(NLATCH) : 1
) (
  input  logic              clk,
  input  logic              Rn,
  input  logic              req0,
  input  logic [AW-1:0]     addr0,
  input  logic [DW-1:0]     data0,
  input  logic              req1,
  input  logic [AW-1:0]     addr1,
  input  logic [DW-1:0]     data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DW-1:0]     lat_d,
  output logic [NLATCH-1:0] lat_ce,
  output logic              lat_Sn,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_ACK
  } state_t;

  localparam logic [3:0] PC_MAX = 4'(PRESET_CYC - 1);
  localparam logic [3:0] HD_MAX = 4'(HOLD - 1);
  localparam logic [AW:0] N_LIM = (AW + 1)'(NLATCH);

  state_t              r_state, w_state;
  logic [3:0]          r_pcnt, w_pcnt;
  logic [3:0]          r_hcnt, w_hcnt;
  logic                r_last, w_last;
  logic                r_own, w_own;
  logic [AW-1:0]       r_addr, w_addr;
  logic [DW-1:0]       r_data, w_data;
  logic                r_flag, w_flag;
  logic [NLATCH-1:0]   r_ce, w_ce;
  logic                r_gnt0, w_gnt0;
  logic                r_gnt1, w_gnt1;
  logic                r_done0, w_done0;
  logic                r_done1, w_done1;
  logic                r_err, w_err;
  logic                r_sn, w_sn;
  logic                r_busy, w_busy;
  logic [NLATCH-1:0]   w_onehot;
  logic                w_oor;
  logic                w_win1;

  // Out-of-range addresses simply match no bit of the decode.
  always_comb begin
    for (int i = 0; i < NLATCH; i++) begin
      w_onehot[i] = (r_addr == AW'(i));
    end
  end

  assign w_oor  = ({1'b0, r_addr} >= N_LIM);
  // r_last = 1 means req1 won last; a tie goes to the other one.
  assign w_win1 = req1 & (~req0 | ~r_last);

  always_comb begin
    w_state = r_state;
    w_pcnt  = r_pcnt;
    w_hcnt  = r_hcnt;
    w_last  = r_last;
    w_own   = r_own;
    w_addr  = r_addr;
    w_data  = r_data;
    w_flag  = r_flag;
    w_ce    = '0;
    w_gnt0  = r_gnt0;
    w_gnt1  = r_gnt1;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    w_err   = 1'b0;
    w_sn    = r_sn;
    unique case (r_state)
      S_INIT: begin
        if (r_pcnt == PC_MAX) begin
          w_sn    = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_pcnt = r_pcnt + 4'd1;
        end
      end
      S_IDLE: begin
        if (req0 | req1) begin
          w_own   = w_win1;
          w_last  = w_win1;
          w_addr  = w_win1 ? addr1 : addr0;
          w_data  = w_win1 ? data1 : data0;
          w_gnt0  = ~w_win1;
          w_gnt1  = w_win1;
          w_hcnt  = '0;
          w_flag  = 1'b0;
          w_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_hcnt == HD_MAX) begin
          w_ce    = w_onehot;
          w_flag  = w_oor;
          w_state = S_STROBE;
        end else begin
          w_hcnt = r_hcnt + 4'd1;
        end
      end
      S_STROBE: begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_done0 = ~r_own;
        w_done1 = r_own;
        w_err   = r_flag;
        w_state = S_ACK;
      end
      S_ACK: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_INIT;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      r_state <= S_INIT;
      r_pcnt  <= '0;
      r_hcnt  <= '0;
      r_last  <= 1'b1;
      r_own   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '1;
      r_flag  <= 1'b0;
      r_ce    <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_sn    <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_pcnt  <= w_pcnt;
      r_hcnt  <= w_hcnt;
      r_last  <= w_last;
      r_own   <= w_own;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_flag  <= w_flag;
      r_ce    <= w_ce;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
      r_err   <= w_err;
      r_sn    <= w_sn;
      r_busy  <= w_busy;
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign err    = r_err;
  assign lat_d  = r_data;
  assign lat_ce = r_ce;
  assign lat_Sn = r_sn;
  assign busy   = r_busy;

endmodule

// File: tb/tb_io_latch_arbiter.sv
// tb_io_latch_arbiter: directed timing checks plus a scoreboard of
// expected writes (owner, strobe, data, err) checked at each done pulse.
module tb_io_latch_arbiter;

  localparam int NL = 6;
  localparam int DW = 8;
  localparam int HD = 2;
  localparam int PC = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          Rn;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, done0, done1, err;
  logic [DW-1:0] lat_d;
  logic [NL-1:0] lat_ce;
  logic          lat_Sn, busy;

  io_latch_arbiter #(
    .NLATCH(NL), .DW(DW), .HOLD(HD), .PRESET_CYC(PC)
  ) dut (
    .clk(clk), .Rn(Rn),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .lat_d(lat_d), .lat_ce(lat_ce),
    .lat_Sn(lat_Sn), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          who;
    logic [NL-1:0] ce;
    logic [DW-1:0] data;
    logic          er;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL-1:0] ce_of(input logic [AW-1:0] a);
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = (int'(a) == i);
    return v;
  endfunction

  task automatic push(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    exp_t e;
    e.who  = w;
    e.ce   = ce_of(a);
    e.data = d;
    e.er   = (int'(a) >= NL);
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  logic [NL-1:0] acc_ce;
  int            ce_cyc;
  logic [DW-1:0] ce_dat;
  logic          bad_bus;

  always @(negedge clk) begin
    exp_t e;
    if (!Rn) begin
      acc_ce  = '0;
      ce_cyc  = 0;
      bad_bus = 1'b0;
    end else begin
      if (gnt0 && gnt1) bad_bus = 1'b1;
      if (lat_ce != '0) begin
        if (!(gnt0 || gnt1)) bad_bus = 1'b1;
        acc_ce = acc_ce | lat_ce;
        ce_cyc++;
        ce_dat = lat_d;
      end
      if (done0 || done1) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'(n_done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_owner", {done1, done0}, e.who ? 2'b10 : 2'b01);
          chk("sb_err", err, e.er);
          chk("sb_ce", acc_ce, e.ce);
          chk("sb_ce_cycles", ce_cyc, (e.ce != '0) ? 1 : 0);
          if (e.ce != '0) chk("sb_data_at_ce", ce_dat, e.data);
          chk("sb_lat_d_at_done", lat_d, e.data);
          chk("sb_bus_conflict", bad_bus, 1'b0);
        end
        acc_ce  = '0;
        ce_cyc  = 0;
        bad_bus = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, nd, g1seen, d0seen;
    logic pg0, pg1;
    int order[$];
    Rn = 1'b0;
    req0 = 1'b1; addr0 = 3'd3; data0 = 8'hA5;
    req1 = 1'b0; addr1 = '0;   data1 = '0;
    #12;
    chk("rst_lat_Sn", lat_Sn, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_lat_d", lat_d, 8'hFF);
    chk("rst_lat_ce", lat_ce, '0);
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_done_err", {done1, done0, err}, 3'b000);
    @(posedge clk); #1;
    Rn = 1'b1;
    push(1'b0, 3'd3, 8'hA5);
    for (int k = 1; k < PC; k++) begin
      tick;
      chk("init_lat_Sn", lat_Sn, 1'b0);
      chk("init_no_gnt", gnt0, 1'b0);
      chk("init_busy", busy, 1'b1);
    end
    tick;
    chk("init_end_lat_Sn", lat_Sn, 1'b1);
    chk("init_end_busy", busy, 1'b0);
    chk("init_end_no_gnt", gnt0, 1'b0);
    // single write: edge E
    tick;
    chk("wr_gnt0_E", gnt0, 1'b1);
    chk("wr_lat_d_E", lat_d, 8'hA5);
    chk("wr_ce_E", lat_ce, '0);
    tick;
    chk("wr_ce_E1", lat_ce, '0);
    tick;
    chk("wr_ce_E2", lat_ce, 6'h08);
    chk("wr_gnt0_E2", gnt0, 1'b1);
    tick;
    chk("wr_done0_E3", done0, 1'b1);
    chk("wr_gnt0_E3", gnt0, 1'b0);
    chk("wr_ce_E3", lat_ce, '0);
    req0 = 1'b0;
    tick;
    chk("wr_done0_E4", done0, 1'b0);
    chk("wr_idle_E4", busy, 1'b0);
    chk("wr_lat_d_hold", lat_d, 8'hA5);
    // out-of-range address on requester 1
    req1 = 1'b1; addr1 = 3'd7; data1 = 8'h5A;
    push(1'b1, 3'd7, 8'h5A);
    tick;
    chk("oor_gnt1", gnt1, 1'b1);
    tick; tick;
    chk("oor_ce", lat_ce, '0);
    tick;
    chk("oor_done_err", {done1, err}, 2'b11);
    req1 = 1'b0;
    tick;
    chk("oor_err_one_cycle", {done1, err}, 2'b00);
    // both requesting: alternating grants
    push(1'b0, 3'd1, 8'h11);
    push(1'b1, 3'd2, 8'h22);
    push(1'b0, 3'd4, 8'h33);
    push(1'b1, 3'd5, 8'h44);
    addr0 = 3'd1; data0 = 8'h11;
    addr1 = 3'd2; data1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    c0 = 0; c1 = 0; pg0 = 1'b0; pg1 = 1'b0;
    for (int k = 0; k < 60 && !(c0 == 2 && c1 == 2); k++) begin
      tick;
      if (gnt0 && !pg0) order.push_back(0);
      if (gnt1 && !pg1) order.push_back(1);
      pg0 = gnt0; pg1 = gnt1;
      if (done0) begin
        c0++;
        if (c0 == 1) begin addr0 = 3'd4; data0 = 8'h33; end
        else req0 = 1'b0;
      end
      if (done1) begin
        c1++;
        if (c1 == 1) begin addr1 = 3'd5; data1 = 8'h44; end
        else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("arb_done_count", c0 + c1, 4);
    chk("arb_grant_count", order.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) chk("arb_order", order[k], k % 2);
    end
    tick;
    // req0 dropped in SETUP, req1 raised then withdrawn before grant
    addr0 = 3'd5; data0 = 8'h3C; req0 = 1'b1;
    push(1'b0, 3'd5, 8'h3C);
    tick;
    chk("drop_gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b1; addr1 = 3'd2; data1 = 8'h99;
    tick;
    req1 = 1'b0;
    g1seen = 0; d0seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (gnt1) g1seen++;
      if (done0) d0seen++;
    end
    chk("drop_no_gnt1", g1seen, 0);
    chk("drop_done0", d0seen, 1);
    // reset during STROBE
    addr0 = 3'd1; data0 = 8'h77; req0 = 1'b1;
    for (int k = 0; k < 10 && lat_ce == '0; k++) tick;
    chk("abort_strobe", lat_ce, 6'h02);
    req0 = 1'b0;
    #2;
    Rn = 1'b0;
    #1;
    chk("abort_ce", lat_ce, '0);
    chk("abort_gnt_done", {gnt1, gnt0, done1, done0}, 4'b0000);
    chk("abort_lat_Sn", lat_Sn, 1'b0);
    chk("abort_busy", busy, 1'b1);
    nd = n_done;
    @(posedge clk); #1;
    Rn = 1'b1;
    for (int k = 1; k < PC; k++) begin
      tick;
      chk("reinit_lat_Sn", lat_Sn, 1'b0);
    end
    tick;
    chk("reinit_end_lat_Sn", lat_Sn, 1'b1);
    chk("reinit_end_busy", busy, 1'b0);
    for (int k = 0; k < 5; k++) tick;
    chk("abort_no_done", n_done, nd);
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_latch_arbiter.md
# io_latch_arbiter

Sequencer and arbiter for the I/O mapper's bank of clock-enabled output latches built from preset-able D flip-flop cells. Two requesters share the single latch write path: req0 is the CPU bus write decoder, req1 is the sound/test loader. The block runs the bank's power-on preset, grants the shared path round-robin, holds data stable for a programmable setup time, issues a one-cycle clock-enable to the addressed latch, and acknowledges the requester.

## Interface
Parameters:
- NLATCH, 8, number of latches in the bank; address width AW = clog2(NLATCH), minimum 1
- DW, 8, latch data width
- HOLD, 2, data setup cycles before strobe; legal range 1..15
- PRESET_CYC, 4, cycles lat_Sn stays low after reset release; legal range 1..15

Ports:
- clk  in  1  system clock, all state on rising edge
- Rn  in  1  asynchronous active-low reset
- req0  in  1  requester 0 (CPU) request level
- addr0  in  AW  requester 0 latch index
- data0  in  DW  requester 0 write data
- req1  in  1  requester 1 (loader) request level
- addr1  in  AW  requester 1 latch index
- data1  in  DW  requester 1 write data
- gnt0, gnt1  out  1 each  grant, high during SETUP and STROBE of the owner's transaction
- done0, done1  out  1 each  one-cycle acknowledge
- err  out  1  one-cycle pulse alongside done when address >= NLATCH
- lat_d  out  DW  shared latch data bus
- lat_ce  out  NLATCH  one-hot latch clock-enable
- lat_Sn  out  1  active-low preset to every latch
- busy  out  1  high in every state except IDLE

## Operation
- States: INIT, IDLE, SETUP, STROBE, ACK.
- Reset (Rn low, asynchronous): state=INIT, lat_Sn=0, lat_d=all ones, lat_ce=0, gnt*=0, done*=0, err=0, busy=1, preset counter=0, last-winner=1, so requester 0 wins the first tie.
- INIT: lat_Sn held low PRESET_CYC cycles after Rn rises, then lat_Sn=1 and state goes to IDLE. Requests are ignored in INIT.
- IDLE, arbitration on each edge:
  - Only one req high: that requester wins.
  - Both high: the requester that is not last-winner wins.
  - Winner's addr and data are captured into internal registers. lat_d is driven from the register, last-winner is updated, gnt goes high, and state goes to SETUP.
- SETUP: lasts HOLD cycles, then STROBE.
- STROBE: lasts one cycle. lat_ce[addr] = 1 if addr < NLATCH. If addr >= NLATCH, lat_ce stays 0 and the err flag is set.
- ACK: lasts one cycle. gnt=0, done of owner=1, err=1 if flagged. Next state is IDLE.
- A requester keeps req, addr and data stable until its done. Once granted, req deassertion is ignored and the transaction completes.
- Dropping req before grant withdraws the request with no effect.
- req still high after done is a new request, eligible in the next IDLE cycle.
- lat_d holds its last written value through IDLE; it changes only on a grant.
- Rn low mid-transaction aborts immediately:
  - lat_ce, gnt and done clear.
  - Latches are preset via lat_Sn.
  - The pending write is lost with no done.

## Timing
- req high at edge E in IDLE: gnt and lat_d valid after E.
- lat_ce high for the single cycle after edge E+HOLD.
- done high for the cycle after edge E+HOLD+1.
- IDLE after edge E+HOLD+2.
- The latch captures lat_d on the clk edge ending the lat_ce cycle. lat_d is stable HOLD cycles before that edge and at least one cycle after it, which covers the 13 ns flip-flop clock-to-Q with margin.
- Minimum request-to-request period per requester: HOLD+3 cycles. With both requesting continuously, grants strictly alternate.
- Outputs are registered; no combinational path from req or addr to any output.

## Test plan
- Reset release, PRESET_CYC=4: lat_Sn low during Rn low plus exactly 4 cycles after; busy=1 throughout, then 0. A req0 during INIT is not granted before IDLE.
- Single write, HOLD=2: req0, addr0=3, data0=0xA5 at edge E.
  - gnt0 high from E.
  - lat_ce=0x08 exactly one cycle after E+2.
  - done0 one cycle after E+3; lat_d=0xA5 through done.
- Simultaneous req0 and req1 held high for 4 transactions:
  - Grant order 0,1,0,1, no overlapping gnt.
  - Each lat_ce pulse carries the owner's data.
- Out-of-range address, NLATCH=6: addr1=7.
  - lat_ce stays 0.
  - done1 and err pulse together for one cycle.
- Requests dropped:
  - req1 dropped before grant: no gnt1, no lat_ce.
  - req0 dropped while in SETUP: strobe and done0 still occur.
- Rn asserted during STROBE: lat_ce, gnt and done clear immediately and lat_Sn goes low. After release, INIT repeats and no done pulse appears for the aborted write.
